run_sequencer: RTL and testbench

// Host-side controller that runs one program on the CPU core: holds the CPU in init,

---
 rtl/run_seq_pkg.sv | 41 ++++
 rtl/run_seq_timer.sv | 35 +++
 rtl/run_sequencer.sv | 173 +++++++++++++++++
 tb/tb_run_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared definitions for the run_sequencer block.
//   - seq_state_t : sequencer FSM states
//   - DEF_*       : default address map, start-pulse length and wait timeout
//   - clog2()     : bits needed to count 0..value-1
//   - cnt_width() : width of the shared start/wait timer
package run_seq_pkg;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_OP_ADDR   = 16;
  localparam int unsigned DEF_RES_ADDR  = 18;
  localparam int unsigned DEF_START_CYC = 2;
  localparam int unsigned DEF_TIMEOUT   = 4096;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WR_HI,
    WR_LO,
    START,
    WAIT,
    READ,
    DONE
  } seq_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
      width++;
    end
    return width;
  endfunction

  // The timer also counts START_CYC (up to 15), so it never drops below 4 bits.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = clog2(timeout);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/run_seq_timer.sv
// run_seq_timer: up-counter with synchronous clear and count enable.
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   clr     in   force count to zero (wins over en)
//   en      in   increment count
//   last    in   terminal count value
//   expired out  count equals last
module run_seq_timer
  import run_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (count == last);

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: host-side controller that runs one CPU program.
// Holds the CPU in init, writes a 16-bit operand to data memory, pulses
// CpuStart, waits for CpuAck (or a timeout), then reads back the result byte.
//   Clk, Reset           clock, synchronous active-low reset
//   Req, Operand         start request (sampled in IDLE) and operand
//   Busy, Valid          not idle / one-cycle completion pulse
//   Result, TimedOut     result byte and timeout flag, held until next Req
//   DmSel                1 = sequencer owns the data-memory port
//   DmWrEn, DmAddr,
//   DmWrData, DmRdData   data-memory port (read data is combinational)
//   CpuInit, CpuStart    CPU init (active high) and start
//   CpuAck               CPU done flag
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned OP_ADDR   = DEF_OP_ADDR,
  parameter int unsigned RES_ADDR  = DEF_RES_ADDR,
  parameter int unsigned START_CYC = DEF_START_CYC,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic [15:0]       Operand,
  output logic              Busy,
  output logic              Valid,
  output logic [7:0]        Result,
  output logic              TimedOut,
  output logic              DmSel,
  output logic              DmWrEn,
  output logic [ADDR_W-1:0] DmAddr,
  output logic [7:0]        DmWrData,
  input  logic [7:0]        DmRdData,
  output logic              CpuInit,
  output logic              CpuStart,
  input  logic              CpuAck
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  localparam logic [ADDR_W-1:0] HI_ADDR  = ADDR_W'(OP_ADDR);
  localparam logic [ADDR_W-1:0] LO_ADDR  = ADDR_W'(OP_ADDR + 1);
  localparam logic [ADDR_W-1:0] RD_ADDR  = ADDR_W'(RES_ADDR);
  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(TIMEOUT - 1);

  seq_state_t       state, state_nxt;
  logic [15:0]      op;
  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_last;
  logic             tmr_expired;

  // One timer serves both START and WAIT: it is held clear outside those
  // states and re-cleared on the START->WAIT edge so WAIT counts from 0.
  run_seq_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk     (Clk),
    .rst_n   (Reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .last    (tmr_last),
    .expired (tmr_expired)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b1;
    tmr_en    = 1'b0;
    tmr_last  = WAIT_LAST;
    Busy      = 1'b1;
    Valid     = 1'b0;
    DmSel     = 1'b0;
    DmWrEn    = 1'b0;
    DmAddr    = '0;
    DmWrData  = '0;
    CpuInit   = 1'b1;
    CpuStart  = 1'b0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Req) state_nxt = INIT;
      end
      INIT: begin
        DmSel     = 1'b1;
        state_nxt = WR_HI;
      end
      WR_HI: begin
        DmSel     = 1'b1;
        DmWrEn    = 1'b1;
        DmAddr    = HI_ADDR;
        DmWrData  = op[15:8];
        state_nxt = WR_LO;
      end
      WR_LO: begin
        DmSel     = 1'b1;
        DmWrEn    = 1'b1;
        DmAddr    = LO_ADDR;
        DmWrData  = op[7:0];
        state_nxt = START;
      end
      START: begin
        CpuInit  = 1'b0;
        CpuStart = 1'b1;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b1;
        tmr_last = START_LAST;
        if (tmr_expired) begin
          tmr_clr   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        CpuInit = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        // Ack has priority over expiry on the same edge.
        if (CpuAck) begin
          state_nxt = READ;
        end else if (tmr_expired) begin
          state_nxt = DONE;
        end
      end
      READ: begin
        DmSel     = 1'b1;
        DmAddr    = RD_ADDR;
        state_nxt = DONE;
      end
      DONE: begin
        Valid     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      op       <= '0;
      Result   <= '0;
      TimedOut <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            op       <= Operand;
            Result   <= '0;
            TimedOut <= 1'b0;
          end
        end
        WAIT: begin
          if (!CpuAck && tmr_expired) begin
            Result   <= '0;
            TimedOut <= 1'b1;
          end
        end
        READ:    Result <= DmRdData;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: self-checking bench for run_sequencer.
// A timeline model (cycles since Req acceptance) predicts every output each
// cycle; directed runs add literal checks on memory contents and latencies,
// followed by randomized runs.
module tb_run_sequencer;

  localparam int ADDR_W = 8;
  localparam int OP_A   = 16;
  localparam int RES_A  = 18;
  localparam int S_CYC  = 2;
  localparam int TMO    = 64;
  localparam int W0     = 4 + S_CYC;   // first WAIT cycle, counted from acceptance

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Req = 1'b0;
  logic [15:0]       Operand = 16'h0000;
  logic              Busy, Valid, TimedOut, DmSel, DmWrEn, CpuInit, CpuStart;
  logic [7:0]        Result, DmWrData, DmRdData;
  logic [ADDR_W-1:0] DmAddr;
  logic              CpuAck;

  always #5 Clk = ~Clk;

  run_sequencer #(
    .ADDR_W    (ADDR_W),
    .OP_ADDR   (OP_A),
    .RES_ADDR  (RES_A),
    .START_CYC (S_CYC),
    .TIMEOUT   (TMO)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .Operand  (Operand),
    .Busy     (Busy),
    .Valid    (Valid),
    .Result   (Result),
    .TimedOut (TimedOut),
    .DmSel    (DmSel),
    .DmWrEn   (DmWrEn),
    .DmAddr   (DmAddr),
    .DmWrData (DmWrData),
    .DmRdData (DmRdData),
    .CpuInit  (CpuInit),
    .CpuStart (CpuStart),
    .CpuAck   (CpuAck)
  );

  // Data memory; the result byte lives in its own variable set by the stimulus.
  logic [7:0] dm [256];
  logic [7:0] res_byte = 8'h00;

  always @(posedge Clk) begin
    if (DmSel && DmWrEn) dm[DmAddr] <= DmWrData;
  end

  assign DmRdData = (DmAddr == ADDR_W'(RES_A)) ? res_byte : dm[DmAddr];

  // CPU model: mode 0 never acks, 1 acks once ack_delay cycles after the
  // CpuStart fall, 2 holds Ack high permanently.
  int ack_mode = 0;
  int ack_delay = 0;
  int ack_cnt = -1;
  logic start_prev_cpu = 1'b0;

  always @(negedge Clk) begin : cpu_model
    int c;
    c = ack_cnt;
    if (start_prev_cpu && !CpuStart && ack_mode == 1) c = ack_delay;
    CpuAck <= (ack_mode == 2) || (c == 0);
    if (c == 0) c = -1;
    else if (c > 0) c = c - 1;
    ack_cnt <= c;
    start_prev_cpu <= CpuStart;
  end

  // Reference model: position in the run is the number of edges since the
  // accepting edge (1 = INIT cycle); READ/DONE positions are fixed once known.
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_read_k = 0;
  int          m_done_k = 0;
  logic [7:0]  m_result = 8'h00;
  bit          m_tmo = 1'b0;
  logic [15:0] m_op = 16'h0000;

  always @(posedge Clk) begin : ref_model
    bit          act;
    int          k, rk, dk;
    logic [7:0]  res;
    bit          tmo;
    logic [15:0] op;
    act = m_active; k = m_k; rk = m_read_k; dk = m_done_k;
    res = m_result; tmo = m_tmo; op = m_op;
    if (!Reset) begin
      act = 1'b0; res = 8'h00; tmo = 1'b0;
    end else if (!act) begin
      if (Req) begin
        act = 1'b1; k = 1; rk = 0; dk = 0; op = Operand; res = 8'h00; tmo = 1'b0;
      end
    end else if (k == dk) begin
      act = 1'b0;
    end else if (k == rk) begin
      res = res_byte; dk = k + 1; k = k + 1;
    end else begin
      if (k >= W0) begin
        if (CpuAck) rk = k + 1;
        else if (k - W0 == TMO - 1) begin
          dk = k + 1; tmo = 1'b1; res = 8'h00;
        end
      end
      k = k + 1;
    end
    m_active <= act; m_k <= k; m_read_k <= rk; m_done_k <= dk;
    m_result <= res; m_tmo <= tmo; m_op <= op;
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   valid_cyc = 0;
  int   valid_cnt = 0;
  bit   cmp_en = 1'b0;
  logic prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; at the falling edge compare every output with the model.
  task automatic tick();
    bit         init_e, hi_e, lo_e, st_e, wt_e, rd_e, dn_e;
    logic [7:0] a_e, d_e;
    @(negedge Clk);
    cyc++;
    init_e = m_active && m_k == 1;
    hi_e   = m_active && m_k == 2;
    lo_e   = m_active && m_k == 3;
    st_e   = m_active && m_k >= 4 && m_k < 4 + S_CYC;
    rd_e   = m_active && m_k == m_read_k;
    dn_e   = m_active && m_k == m_done_k;
    wt_e   = m_active && m_k >= W0 && !rd_e && !dn_e;
    a_e    = hi_e ? 8'(OP_A) : lo_e ? 8'(OP_A + 1) : rd_e ? 8'(RES_A) : 8'h00;
    d_e    = hi_e ? m_op[15:8] : lo_e ? m_op[7:0] : 8'h00;
    if (cmp_en) begin
      chk("busy", Busy, m_active);
      chk("valid", Valid, dn_e);
      chk("dmsel", DmSel, init_e || hi_e || lo_e || rd_e);
      chk("dmwren", DmWrEn, hi_e || lo_e);
      chk("dmaddr", DmAddr, a_e);
      chk("dmwrdata", DmWrData, d_e);
      chk("cpuinit", CpuInit, !(st_e || wt_e));
      chk("cpustart", CpuStart, st_e);
      chk("result", Result, m_result);
      chk("timedout", TimedOut, m_tmo);
    end
    if (prev_start === 1'b1 && CpuStart === 1'b0) fall_cyc = cyc;
    if (Valid === 1'b1) begin
      valid_cyc = cyc;
      valid_cnt++;
    end
    prev_start = CpuStart;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_run(input logic [15:0] op);
    Operand = op;
    Req = 1'b1;
    tick();
    Req = 1'b0;
    Operand = 16'($urandom);
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      tick();
      if (Valid === 1'b1) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int vc0;
    int n;

    // Reset state
    idle(2);
    cmp_en = 1'b1;
    idle(1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_valid", Valid, 1'b0);
    chk("rst_cpuinit", CpuInit, 1'b1);
    chk("rst_dmsel", DmSel, 1'b0);
    chk("rst_result", Result, 8'h00);
    chk("rst_dmaddr", DmAddr, 8'h00);
    Reset = 1'b1;
    idle(2);

    // Normal run: 0xFE01, Ack 50 cycles after Start falls
    res_byte = 8'hFF; ack_mode = 1; ack_delay = 50;
    idle(2);
    vc0 = valid_cnt;
    start_run(16'hFE01);
    wait_valid(200, "a_valid_seen");
    chk("a_result", Result, 8'hFF);
    chk("a_timedout", TimedOut, 1'b0);
    chk("a_fall_to_valid", 32'(valid_cyc - fall_cyc), 32'd52);
    idle(3);
    chk("a_dm16", dm[16], 8'hFE);
    chk("a_dm17", dm[17], 8'h01);
    chk("a_valid_once", 32'(valid_cnt - vc0), 32'd1);

    // Timeout: CPU never acks
    res_byte = 8'hEE; ack_mode = 0;
    idle(2);
    start_run(16'h8001);
    wait_valid(200, "t_valid_seen");
    chk("t_fall_to_valid", 32'(valid_cyc - fall_cyc), 32'd64);
    chk("t_timedout", TimedOut, 1'b1);
    chk("t_result", Result, 8'h00);
    idle(2);

    // Ack stuck high through START
    res_byte = 8'h5A; ack_mode = 2;
    idle(2);
    start_run(16'h0102);
    wait_valid(50, "s_valid_seen");
    chk("s_fall_to_valid", 32'(valid_cyc - fall_cyc), 32'd2);
    chk("s_result", Result, 8'h5A);
    chk("s_timedout", TimedOut, 1'b0);
    idle(2);

    // Second Req during WAIT is ignored
    res_byte = 8'h3C; ack_mode = 1; ack_delay = 20;
    idle(2);
    vc0 = valid_cnt;
    start_run(16'hABCD);
    idle(10);
    Operand = 16'h1234; Req = 1'b1;
    tick();
    Req = 1'b0;
    wait_valid(100, "q_valid_seen");
    chk("q_result", Result, 8'h3C);
    idle(4);
    chk("q_dm16", dm[16], 8'hAB);
    chk("q_dm17", dm[17], 8'hCD);
    chk("q_valid_once", 32'(valid_cnt - vc0), 32'd1);

    // Reset in the middle of WAIT aborts without Valid
    ack_mode = 0;
    idle(2);
    vc0 = valid_cnt;
    start_run(16'h5555);
    idle(12);
    Reset = 1'b0;
    tick();
    chk("r_busy", Busy, 1'b0);
    chk("r_cpuinit", CpuInit, 1'b1);
    chk("r_valid", Valid, 1'b0);
    Reset = 1'b1;
    idle(80);
    chk("r_no_valid", 32'(valid_cnt - vc0), 32'd0);
    res_byte = 8'h77; ack_mode = 1; ack_delay = 5;
    start_run(16'h0F0F);
    wait_valid(100, "r2_valid_seen");
    chk("r2_result", Result, 8'h77);
    chk("r2_fall_to_valid", 32'(valid_cyc - fall_cyc), 32'd7);
    idle(2);
    chk("r2_dm16", dm[16], 8'h0F);

    // Operand 0 with Ack landing on the expiry edge
    res_byte = 8'h00; ack_mode = 1; ack_delay = 63;
    idle(2);
    start_run(16'h0000);
    wait_valid(200, "z_valid_seen");
    chk("z_fall_to_valid", 32'(valid_cyc - fall_cyc), 32'd65);
    chk("z_timedout", TimedOut, 1'b0);
    chk("z_result", Result, 8'h00);
    idle(2);
    chk("z_dm16", dm[16], 8'h00);
    chk("z_dm17", dm[17], 8'h00);

    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      res_byte  = 8'($urandom);
      ack_mode  = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1));
      ack_delay = int'($urandom_range(0, 70));
      start_run(16'($urandom));
      n = int'($urandom_range(60, 150));
      for (int c = 0; c < n; c++) begin
        Req     = ($urandom_range(0, 7) == 0);
        Operand = 16'($urandom);
        Reset   = !((it % 7 == 3) && (c == 20));
        tick();
      end
      Req = 1'b0; Reset = 1'b1;
      for (int c = 0; c < 100 && Busy !== 1'b0; c++) tick();
    end

    ack_mode = 0;
    for (int c = 0; c < 300 && Busy !== 1'b0; c++) tick();
    chk("final_idle", Busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
